// File: rtl/mem_copy_master_if.sv
// -----------------------------------------------------------------------------
// mem_copy_master_if
// Purpose : single-port word memory bus between a bus initiator (master) and
//           a word memory (slave).
// Signals : MEM_ADDR  [WIDTH-1:0]  word address            (master -> slave)
//           MEM_DIN   [31:0]       write data              (master -> slave)
//           MEM_RW                 1 = write, 0 = read     (master -> slave)
//           MEM_VALID              access enable           (master -> slave)
//           MEM_DOUT  [31:0]       registered read data,   (slave -> master)
//                                  valid the cycle after a read access
// -----------------------------------------------------------------------------
interface mem_copy_master_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] MEM_ADDR;
    logic [31:0]      MEM_DIN;
    logic             MEM_RW;
    logic             MEM_VALID;
    logic [31:0]      MEM_DOUT;

    modport master (
        output MEM_ADDR,
        output MEM_DIN,
        output MEM_RW,
        output MEM_VALID,
        input  MEM_DOUT
    );

    modport slave (
        input  MEM_ADDR,
        input  MEM_DIN,
        input  MEM_RW,
        input  MEM_VALID,
        output MEM_DOUT
    );
endinterface

// File: rtl/mem_copy_master.sv
// -----------------------------------------------------------------------------
// mem_copy_master
// Purpose : copies LEN 32-bit words from SRC to DST inside one single-port
//           memory, one read cycle plus one write cycle per word, ascending
//           addresses, modulo-2**WIDTH pointer arithmetic.
// Ports   : CLK        system clock, rising edge
//           RESET_N    asynchronous active-low reset
//           START      one-cycle request, sampled only when idle
//           SRC/DST    first source / destination word address
//           LEN        word count 0 .. 2**WIDTH
//           ABORT      stop at the next word boundary
//           BUSY       transfer in progress
//           DONE       one-cycle completion pulse
//           ABORTED    qualifies DONE: transfer ended by ABORT
//           CHKSUM     (optional) modulo-2**32 sum of words written
//           mem        memory bus, master side of mem_copy_master_if
// Options : define MEM_COPY_CHECKSUM_EN to add the CHKSUM output and adder.
// -----------------------------------------------------------------------------
module mem_copy_master #(
    parameter int WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [WIDTH-1:0]  SRC,
    input  logic [WIDTH-1:0]  DST,
    input  logic [WIDTH:0]    LEN,
    input  logic              ABORT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ABORTED,
`ifdef MEM_COPY_CHECKSUM_EN
    output logic [31:0]       CHKSUM,
`endif
    mem_copy_master_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] PTR_ONE  = WIDTH'(1);
    localparam logic [WIDTH:0]   CNT_ONE  = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0]   CNT_ZERO = (WIDTH + 1)'(0);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_src;
    logic [WIDTH-1:0] r_dst;
    logic [WIDTH:0]   r_cnt;
    logic             r_abort_seen;
    logic [WIDTH-1:0] w_src_nxt;
    logic [WIDTH-1:0] w_dst_nxt;
    logic [WIDTH:0]   w_cnt_nxt;
    logic             w_abort_nxt;

    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic             r_mem_valid;
    logic             r_mem_rw;
    logic [WIDTH-1:0] r_mem_addr;
    logic [31:0]      r_mem_din;
    logic             r_din_fwd;
    logic             w_busy;
    logic             w_done;
    logic             w_aborted;
    logic             w_mem_valid;
    logic             w_mem_rw;
    logic [WIDTH-1:0] w_mem_addr;
    logic [31:0]      w_mem_din;
    logic             w_din_fwd;

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a word ends in FIN when the count is exhausted or an
    // abort was seen during its RD or WR cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    if (LEN != CNT_ZERO) begin
                        w_state_nxt = S_RD;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                w_state_nxt = S_WR;
            end
            S_WR: begin
                if ((r_cnt == CNT_ONE) || r_abort_seen || ABORT) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_RD;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pointer, count and abort-flag next values.
    always_comb begin
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = r_abort_seen;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_src_nxt   = SRC;
                    w_dst_nxt   = DST;
                    w_cnt_nxt   = LEN;
                    w_abort_nxt = 1'b0;
                end else begin
                    w_abort_nxt = r_abort_seen;
                end
            end
            S_RD: begin
                w_abort_nxt = r_abort_seen | ABORT;
            end
            S_WR: begin
                // Pointers wrap silently at 2**WIDTH.
                w_src_nxt   = r_src + PTR_ONE;
                w_dst_nxt   = r_dst + PTR_ONE;
                w_cnt_nxt   = r_cnt - CNT_ONE;
                w_abort_nxt = r_abort_seen | ABORT;
            end
            default: begin
                w_abort_nxt = r_abort_seen;
            end
        endcase
    end

    // Pointer, count and abort-flag registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_src        <= {WIDTH{1'b0}};
            r_dst        <= {WIDTH{1'b0}};
            r_cnt        <= CNT_ZERO;
            r_abort_seen <= 1'b0;
        end else begin
            r_src        <= w_src_nxt;
            r_dst        <= w_dst_nxt;
            r_cnt        <= w_cnt_nxt;
            r_abort_seen <= w_abort_nxt;
        end
    end

    // Output logic: bus outputs follow the state being entered so the access
    // lines up with the RD/WR state; DONE follows the FIN state by one cycle.
    always_comb begin
        w_busy      = (w_state_nxt != S_IDLE);
        w_done      = (r_state == S_FIN);
        w_aborted   = (r_state == S_FIN) && r_abort_seen;
        w_mem_valid = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
        w_mem_rw    = (w_state_nxt == S_WR);
        w_din_fwd   = (w_state_nxt == S_WR);
        if (r_state == S_WR) begin
            w_mem_din = mem.MEM_DOUT;
        end else begin
            w_mem_din = r_mem_din;
        end
        case (w_state_nxt)
            S_RD:    w_mem_addr = w_src_nxt;
            S_WR:    w_mem_addr = w_dst_nxt;
            default: w_mem_addr = r_mem_addr;
        endcase
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= {WIDTH{1'b0}};
            r_mem_din   <= 32'd0;
            r_din_fwd   <= 1'b0;
        end else begin
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_aborted   <= w_aborted;
            r_mem_valid <= w_mem_valid;
            r_mem_rw    <= w_mem_rw;
            r_mem_addr  <= w_mem_addr;
            r_mem_din   <= w_mem_din;
            r_din_fwd   <= w_din_fwd;
        end
    end

    assign BUSY          = r_busy;
    assign DONE          = r_done;
    assign ABORTED       = r_aborted;
    assign mem.MEM_VALID = r_mem_valid;
    assign mem.MEM_RW    = r_mem_rw;
    assign mem.MEM_ADDR  = r_mem_addr;
    // The read word only exists in the memory's output register during the
    // WR cycle, so it is forwarded straight from that register (a
    // register-to-register path); r_mem_din keeps it afterwards.
    assign mem.MEM_DIN   = r_din_fwd ? mem.MEM_DOUT : r_mem_din;

`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] r_chksum;
    logic [31:0] w_chksum_nxt;

    // Checksum next value: cleared on accepted START, accumulates each write.
    always_comb begin
        w_chksum_nxt = r_chksum;
        if ((r_state == S_IDLE) && START) begin
            w_chksum_nxt = 32'd0;
        end else if (r_state == S_WR) begin
            w_chksum_nxt = r_chksum + mem.MEM_DOUT;
        end else begin
            w_chksum_nxt = r_chksum;
        end
    end

    // Checksum register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_chksum <= 32'd0;
        end else begin
            r_chksum <= w_chksum_nxt;
        end
    end

    assign CHKSUM = r_chksum;
`endif

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus initiator that drives the single-port word memory interface: `MEM_ADDR`, `MEM_DIN`, `MEM_RW`, `MEM_VALID` out; `MEM_DOUT` in.
- Copies a block of `LEN` 32-bit words from `SRC` to `DST` inside the same memory. One read cycle plus one write cycle per word.
- Sits between the control/test logic and the memory. Lets the testbench and sequencers move or duplicate data without touching the memory port directly.

Parameters:
- `WIDTH`, default 8: memory address width in bits. Memory depth is 2**WIDTH words.

Ports:
- `CLK`  in  1  system clock, rising-edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  one-cycle request; sampled only in IDLE.
- `SRC`  in  WIDTH  first source word address; latched on accepted START.
- `DST`  in  WIDTH  first destination word address; latched on accepted START.
- `LEN`  in  WIDTH+1  word count, 0 to 2**WIDTH; latched on accepted START.
- `ABORT`  in  1  stops the transfer at the next word boundary.
- `BUSY`  out  1  high from the cycle after START acceptance until DONE.
- `DONE`  out  1  one-cycle completion pulse.
- `ABORTED`  out  1  valid with DONE; 1 if the transfer ended by ABORT.
- `MEM_ADDR`  out  WIDTH  memory address.
- `MEM_DIN`  out  32  memory write data.
- `MEM_RW`  out  1  1 = write, 0 = read.
- `MEM_VALID`  out  1  memory access enable.
- `MEM_DOUT`  in  32  registered memory read data. Valid in the cycle after a read access.

Behaviour:
- Reset: asynchronous on RESET_N low. State=IDLE; BUSY, DONE, ABORTED, MEM_VALID, MEM_RW = 0; MEM_ADDR = 0; MEM_DIN = 0; internal src/dst pointers and count = 0.
- All outputs are registered.
- States and transitions:
  - IDLE: on START with LEN!=0, latch SRC/DST/LEN and go to RD. On START with LEN=0, go to FIN with no memory access. START in any other state is ignored.
  - RD: drive MEM_VALID=1, MEM_RW=0, MEM_ADDR=src. Next state WR.
  - WR: drive MEM_VALID=1, MEM_RW=1, MEM_ADDR=dst, MEM_DIN=MEM_DOUT (the data returned from the RD cycle). Then increment src and dst, and decrement count. Next state is FIN if count reaches 0 or ABORT is sampled high during RD or WR; otherwise RD.
  - FIN: MEM_VALID=0, DONE=1 for exactly one cycle, ABORTED set accordingly, BUSY=0 in the same cycle. Next state IDLE.
- Outside RD/WR, MEM_VALID=0; MEM_ADDR and MEM_DIN hold their last values.
- Throughput: 2 cycles per word. Latency from START to DONE = 2*LEN + 2 cycles.
- Address arithmetic is modulo 2**WIDTH; pointers wrap from 2**WIDTH-1 to 0 silently.
- LEN = 2**WIDTH copies the whole memory.
- Overlapping regions are copied in ascending address order with no hazard protection. With DST = SRC+1 the first word propagates forward (defined, tested).
- ABORT is word-granular: the current word's write always completes; no partial word is ever written. ABORT in IDLE has no effect.
- Reset mid-transfer: immediate return to IDLE with all outputs at reset values. The memory keeps whatever words were already written.

Optional Feature:
- Macro `MEM_COPY_CHECKSUM_EN`.
- Defined: adds output `CHKSUM [31:0]`, the 32-bit modulo-2**32 sum of every word written during the current transfer.
  - Cleared on accepted START.
  - Updated in each WR cycle.
  - Holds after DONE until the next START.
  - Reset value 0.
- Undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
- Preload mem[0x10..0x13] = 0xA0, 0xA1, 0xA2, 0xA3. START with SRC=0x10, DST=0x40, LEN=4 -> mem[0x40..0x43] = 0xA0..0xA3; DONE exactly 10 cycles after START; ABORTED=0; with checksum enabled, CHKSUM=0x286.
- START with LEN=0 -> no MEM_VALID pulse; DONE 2 cycles later.
- SRC=0xFE, DST=0x02, LEN=4, preload mem[0xFE]=1, mem[0xFF]=2, mem[0x00]=3, mem[0x01]=4 -> mem[0x02..0x05] = 1, 2, 3, 4 (source pointer wraps).
- LEN=8 with ABORT pulsed during the 3rd word's RD cycle -> exactly 3 words written; DONE with ABORTED=1; a 4th-word write never occurs.
- RESET_N low during word 2 of LEN=5 -> outputs at reset values asynchronously; word 1 is in memory; a subsequent START runs normally.
- Second START pulsed while BUSY -> ignored; the first transfer completes unchanged and DONE pulses once.
